if_stage_ctrl: RTL and testbench
================================

IF_STAGE_CTRL -- requirements
Module: if_stage_ctrl

Interface
REQ-001 The block SHALL have parameter RESET_PC, default 32'h0000_0000, the fetch address loaded on reset.
REQ-002 The block SHALL have parameter CNT_W, default 32, the width of the taken-branch counter.
REQ-003 The block SHALL have port clk, input, 1, the single clock; all state updates on its rising edge.
REQ-004 The block SHALL have port reset, input, 1, the reset: synchronous and active-high.
REQ-005 The block SHALL have port branch_taken, input, 1, the ID-stage branch decision (Branch AND Zero).
REQ-006 The block SHALL have port branch_target, input, 32, the ID-stage computed branch address.
REQ-007 The block SHALL have port stall, input, 1, the hazard-unit hold request (load-use).
REQ-008 The block SHALL have port instr_in, input, 32, the instruction-memory read data for pc_out, valid combinationally the same cycle.
REQ-009 The block SHALL have port pc_out, output, 32, the current fetch address to instruction memory.
REQ-010 The block SHALL have port instr_id, output, 32, the IF/ID registered instruction.
REQ-011 The block SHALL have port pc_plus4_id, output, 32, the IF/ID registered pc_out+4.
REQ-012 The block SHALL have port valid_id, output, 1, set when instr_id holds a real fetched instruction.
REQ-013 The block SHALL have port branch_cnt, output, CNT_W, the count of accepted taken branches.

Function
REQ-014 Next-PC priority SHALL be: reset, then stall, then branch_taken, then sequential pc_out+4.
REQ-015 With stall=1, pc_out, instr_id, pc_plus4_id and valid_id SHALL hold, and branch_taken SHALL be ignored that cycle.
REQ-016 With stall=0 and branch_taken=1, pc_out SHALL load {branch_target[31:2],2'b00} at the next edge, with one-cycle redirect latency.
REQ-017 On the same edge as an accepted branch, IF/ID SHALL flush: instr_id=32'h0000_0000 (NOP), pc_plus4_id=0, valid_id=0.
REQ-018 With stall=0 and branch_taken=0, IF/ID SHALL capture instr_in and pc_out+4 with valid_id=1, and pc_out SHALL advance by 4.
REQ-019 PC increment SHALL be modulo 2^32: pc_out 32'hFFFF_FFFC SHALL advance to 32'h0000_0000.
REQ-020 Back-to-back accepted branches SHALL each redirect and flush, with no instruction between them marked valid.
REQ-021 All outputs SHALL be registered; no combinational path from any input to any output except none.

Reset
REQ-022 With reset=1 at an edge, pc_out SHALL become RESET_PC and instr_id, pc_plus4_id, valid_id and branch_cnt SHALL become 0, regardless of stall or branch_taken.
REQ-023 Reset asserted mid-stall or mid-redirect SHALL discard the pending operation.
REQ-024 On the first edge after reset deasserts, the block SHALL fetch RESET_PC into IF/ID.

Configuration
REQ-025 With macro IF_BRANCH_CNT_EN defined, branch_cnt SHALL increment by 1 per accepted branch (stall=0, branch_taken=1) and saturate at all-ones.
REQ-026 Without IF_BRANCH_CNT_EN, branch_cnt SHALL remain present and be tied to 0, and no counter logic SHALL be synthesised.

Structure
REQ-027 The shared package mips_pkg SHALL hold INSTR_W=32, PC_INC=4 and NOP_INSTR=32'h0000_0000.
REQ-028 The IF/ID register (capture, hold, flush) SHALL be a sub-module named if_id_reg, while the PC register and next-PC mux SHALL stay in if_stage_ctrl.

Verification
REQ-029 Reset test: reset=1 for 2 cycles, then release -> pc_out=RESET_PC and valid_id=0 during reset; on the first edge after release instr_id=instr_in and pc_out=RESET_PC+4.
REQ-030 Sequential fetch test: 4 cycles with no stall -> pc_out steps 0,4,8,C, and pc_plus4_id lags by one cycle.
REQ-031 Taken-branch test: branch_taken=1 with branch_target=32'h0000_0040 -> next pc_out=0x40, instr_id=0, valid_id=0, and branch_cnt+1 when IF_BRANCH_CNT_EN is defined.
REQ-032 Stall-over-branch test: stall=1 with branch_taken=1 -> all outputs hold, branch_cnt is unchanged, and no redirect occurs.
REQ-033 Wrap and alignment test: pc_out=32'hFFFF_FFFC with no stall -> next pc_out=0; branch_target=32'h0000_0043 -> pc_out=0x40.
REQ-034 Counter saturation test: with CNT_W=2, 5 accepted branches -> branch_cnt=2'b11, and without the macro branch_cnt=0 throughout.

Source files
------------

// File: rtl/mips_pkg.sv
// Shared constants and types for the MIPS fetch stage: instruction width,
// PC increment, NOP encoding and the IF/ID register operation select.
package mips_pkg;

   localparam int          INSTR_W   = 32;
   localparam logic [31:0] PC_INC    = 32'd4;
   localparam logic [31:0] NOP_INSTR = 32'h0000_0000;

   typedef enum logic [1:0] {
      IFID_HOLD    = 2'd0,
      IFID_CAPTURE = 2'd1,
      IFID_FLUSH   = 2'd2
   } ifid_op_e;

   // Instruction fetches are word aligned, so the low two bits are dropped.
   function automatic logic [31:0] align_word(input logic [31:0] addr);
      return {addr[31:2], 2'b00};
   endfunction

endpackage

// File: rtl/if_id_reg.sv
// IF/ID pipeline register: captures a fetched instruction, holds it on a
// stall, or flushes it to a NOP when a taken branch redirects fetch.
module if_id_reg
   import mips_pkg::*;
(
   input  logic               clk,
   input  logic               reset,
   input  ifid_op_e           op,
   input  logic [INSTR_W-1:0] instr_in,
   input  logic [31:0]        pc_plus4_in,
   output logic [INSTR_W-1:0] instr_id,
   output logic [31:0]        pc_plus4_id,
   output logic               valid_id
);

   // NOTE: sequential state uses non-blocking assignments so every register
   // samples its inputs as they were before the edge, regardless of order.
   always_ff @(posedge clk) begin
      if (reset) begin
         instr_id    <= NOP_INSTR;
         pc_plus4_id <= '0;
         valid_id    <= 1'b0;
      end else begin
         case (op)
            IFID_CAPTURE: begin
               instr_id    <= instr_in;
               pc_plus4_id <= pc_plus4_in;
               valid_id    <= 1'b1;
            end
            IFID_FLUSH: begin
               instr_id    <= NOP_INSTR;
               pc_plus4_id <= '0;
               valid_id    <= 1'b0;
            end
            default: ;
         endcase
      end
   end

endmodule

// File: rtl/if_stage_ctrl.sv
// MIPS IF stage: PC register, next-PC selection and the IF/ID register.
// Define IF_BRANCH_CNT_EN to build the saturating taken-branch counter.
module if_stage_ctrl
   import mips_pkg::*;
#(
   parameter logic [31:0] RESET_PC = 32'h0000_0000,
   parameter int          CNT_W    = 32
)(
   input  logic               clk,
   input  logic               reset,
   input  logic               branch_taken,
   input  logic [31:0]        branch_target,
   input  logic               stall,
   input  logic [INSTR_W-1:0] instr_in,
   output logic [31:0]        pc_out,
   output logic [INSTR_W-1:0] instr_id,
   output logic [31:0]        pc_plus4_id,
   output logic               valid_id,
   output logic [CNT_W-1:0]   branch_cnt
);

   logic [31:0] pc_seq;
   logic [31:0] pc_next;
   ifid_op_e    ifid_op;

   // Wraps modulo 2^32 naturally through the 32-bit add.
   assign pc_seq = pc_out + PC_INC;

   // Priority below reset: stall holds everything, then branch, then sequential.
   // NOTE: every always_comb output gets a default first so no path leaves it
   // unassigned, which would otherwise infer a latch.
   always_comb begin
      pc_next = pc_out;
      ifid_op = IFID_HOLD;
      if (!stall) begin
         if (branch_taken) begin
            pc_next = align_word(branch_target);
            ifid_op = IFID_FLUSH;
         end else begin
            pc_next = pc_seq;
            ifid_op = IFID_CAPTURE;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (reset) pc_out <= RESET_PC;
      else       pc_out <= pc_next;
   end

   if_id_reg u_if_id_reg (
      .clk         (clk),
      .reset       (reset),
      .op          (ifid_op),
      .instr_in    (instr_in),
      .pc_plus4_in (pc_seq),
      .instr_id    (instr_id),
      .pc_plus4_id (pc_plus4_id),
      .valid_id    (valid_id)
   );

`ifdef IF_BRANCH_CNT_EN
   logic branch_accepted;
   assign branch_accepted = branch_taken && !stall;

   always_ff @(posedge clk) begin
      if (reset)
         branch_cnt <= '0;
      else if (branch_accepted && (branch_cnt != {CNT_W{1'b1}}))
         branch_cnt <= branch_cnt + 1'b1;
   end
`else
   assign branch_cnt = '0;
`endif

endmodule

// File: tb/tb_if_stage_ctrl.sv
// Self-checking bench for if_stage_ctrl: directed scenarios followed by
// randomized traffic, all checked against a behavioural fetch-stage model.
module tb_if_stage_ctrl;

   localparam logic [31:0] RESET_PC = 32'h0000_0000;
   localparam int          CNT_W    = 2;

   logic             clk = 1'b0;
   logic             reset;
   logic             branch_taken;
   logic [31:0]      branch_target;
   logic             stall;
   logic [31:0]      instr_in;
   logic [31:0]      pc_out;
   logic [31:0]      instr_id;
   logic [31:0]      pc_plus4_id;
   logic             valid_id;
   logic [CNT_W-1:0] branch_cnt;

   int n_vec = 0;
   int n_err = 0;

   // Reference state of the fetch stage.
   logic [31:0] m_pc, m_instr, m_p4;
   logic        m_valid;
   int          m_cnt;

   if_stage_ctrl #(.RESET_PC(RESET_PC), .CNT_W(CNT_W)) dut (
      .clk           (clk),
      .reset         (reset),
      .branch_taken  (branch_taken),
      .branch_target (branch_target),
      .stall         (stall),
      .instr_in      (instr_in),
      .pc_out        (pc_out),
      .instr_id      (instr_id),
      .pc_plus4_id   (pc_plus4_id),
      .valid_id      (valid_id),
      .branch_cnt    (branch_cnt)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_vec++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   // Apply one cycle of inputs, advance the model, then compare every output.
   task automatic cycle(input logic rst, input logic stl, input logic bt,
                        input logic [31:0] tgt, input logic [31:0] ins);
      int max_cnt;
      max_cnt = (1 << CNT_W) - 1;
      @(negedge clk);
      reset = rst; stall = stl; branch_taken = bt; branch_target = tgt; instr_in = ins;
      @(posedge clk);
      if (rst) begin
         m_pc = RESET_PC; m_instr = 0; m_p4 = 0; m_valid = 0; m_cnt = 0;
      end else if (!stl) begin
         if (bt) begin
            m_pc    = (tgt / 4) * 4;
            m_instr = 0; m_p4 = 0; m_valid = 0;
`ifdef IF_BRANCH_CNT_EN
            if (m_cnt < max_cnt) m_cnt = m_cnt + 1;
`endif
         end else begin
            m_instr = ins;
            m_p4    = m_pc + 32'd4;
            m_valid = 1;
            m_pc    = m_pc + 32'd4;
         end
      end
      #1;
      check("pc_out",      pc_out,             m_pc);
      check("instr_id",    instr_id,           m_instr);
      check("pc_plus4_id", pc_plus4_id,        m_p4);
      check("valid_id",    {31'd0, valid_id},  {31'd0, m_valid});
      check("branch_cnt",  32'(branch_cnt),    32'(m_cnt));
   endtask

   initial begin
      logic [31:0] held_pc, held_instr;
      m_pc = 0; m_instr = 0; m_p4 = 0; m_valid = 0; m_cnt = 0;
      reset = 1'b1; stall = 1'b0; branch_taken = 1'b0; branch_target = '0; instr_in = '0;

      // Reset for two cycles, even with stall and branch requested.
      cycle(1, 1, 1, 32'h0000_0100, 32'h1111_1111);
      cycle(1, 0, 0, 32'h0,         32'h2222_2222);
      check("reset_pc", pc_out, RESET_PC);

      // First edge after release fetches RESET_PC; then sequential fetch.
      cycle(0, 0, 0, 32'h0, 32'hAAAA_0000);
      check("first_fetch_instr", instr_id, 32'hAAAA_0000);
      check("first_fetch_pc",    pc_out,   RESET_PC + 32'd4);
      for (int i = 0; i < 4; i++) cycle(0, 0, 0, 32'h0, $urandom);

      // Taken branch to 0x40 flushes IF/ID.
      cycle(0, 0, 1, 32'h0000_0040, 32'hDEAD_BEEF);
      check("branch_pc",    pc_out,   32'h0000_0040);
      check("branch_flush", instr_id, 32'h0);

      // Stall over branch holds everything.
      cycle(0, 0, 0, 32'h0, 32'h1234_5678);
      held_pc = pc_out; held_instr = instr_id;
      cycle(0, 1, 1, 32'h0000_0800, 32'h8765_4321);
      check("stall_pc_hold",    pc_out,   held_pc);
      check("stall_instr_hold", instr_id, held_instr);

      // Wrap-around and target alignment.
      cycle(0, 0, 1, 32'hFFFF_FFFC, $urandom);
      cycle(0, 0, 0, 32'h0, 32'h0BAD_F00D);
      check("wrap_pc", pc_out, 32'h0000_0000);
      cycle(0, 0, 1, 32'h0000_0043, $urandom);
      check("align_pc", pc_out, 32'h0000_0040);

      // Back-to-back branches, enough to saturate a 2-bit counter.
      for (int i = 0; i < 5; i++) cycle(0, 0, 1, $urandom, $urandom);
`ifdef IF_BRANCH_CNT_EN
      check("cnt_saturated", 32'(branch_cnt), 32'h3);
`else
      check("cnt_tied_zero", 32'(branch_cnt), 32'h0);
`endif

      // Reset mid-stall and mid-redirect discards the pending operation.
      cycle(0, 1, 0, 32'h0, $urandom);
      cycle(1, 1, 1, 32'h0000_0200, $urandom);
      cycle(0, 0, 1, 32'h0000_0300, $urandom);
      cycle(1, 0, 1, 32'h0000_0400, $urandom);
      check("reset_discard_pc", pc_out, RESET_PC);

      // Randomized traffic.
      for (int i = 0; i < 300; i++) begin
         cycle(($urandom_range(0, 99) < 3),
               ($urandom_range(0, 99) < 25),
               ($urandom_range(0, 99) < 25),
               $urandom, $urandom);
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
